// File: rtl/imm_gen_if.sv
// Handshake bundle for imm_gen_pipe: upstream instruction in,
// downstream decoded immediate out, each with valid/ready.
interface imm_gen_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
);
  logic             i_valid;
  logic             o_ready;
  logic [31:0]      i_instr;
  logic [TAG_W-1:0] i_tag;
  logic             o_valid;
  logic             i_ready;
  logic [XLEN-1:0]  o_imm;
  logic [2:0]       o_fmt;
  logic             o_illegal;
  logic [TAG_W-1:0] o_tag;

  modport master (
    output i_valid, i_instr, i_tag, i_ready,
    input  o_ready, o_valid, o_imm, o_fmt, o_illegal, o_tag
  );

  modport slave (
    input  i_valid, i_instr, i_tag, i_ready,
    output o_ready, o_valid, o_imm, o_fmt, o_illegal, o_tag
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// Pipelined RV32I/RV64I immediate decoder with a 2-entry skid buffer.
// Ports: i_clk, i_rst_n (async low), i_flush, bus (imm_gen_if.slave).
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input logic      i_clk,
  input logic      i_rst_n,
  input logic      i_flush,
  imm_gen_if.slave bus
);

  localparam bit X64 = (XLEN == 64);

  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_FENCE = 7'b0001111;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_REG32 = 7'b0111011;

  typedef enum logic [2:0] {
    F_NONE, F_I, F_S, F_B, F_U, F_J, F_Z, F_R
  } fmt_e;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } ent_t;

  logic [31:0]     w_in;
  logic [2:0]      w_f3;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_s;
  logic [XLEN-1:0] w_imm_b;
  logic [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0] w_imm_j;
  logic [XLEN-1:0] w_zimm;
  logic [XLEN-1:0] w_sh5;
  logic [XLEN-1:0] w_sh6;
  logic [XLEN-1:0] w_imm;
  fmt_e            w_fmt;
  logic            w_ill;
  ent_t            w_ent;

  assign w_in = bus.i_instr;
  assign w_f3 = w_in[14:12];

  assign w_imm_i = XLEN'($signed(w_in[31:20]));
  assign w_imm_s = XLEN'($signed({w_in[31:25], w_in[11:7]}));
  assign w_imm_b = XLEN'($signed({w_in[31], w_in[7],
                                  w_in[30:25], w_in[11:8], 1'b0}));
  assign w_imm_u = XLEN'($signed({w_in[31:12], 12'b0}));
  assign w_imm_j = XLEN'($signed({w_in[31], w_in[19:12],
                                  w_in[20], w_in[30:21], 1'b0}));
  assign w_zimm  = XLEN'(w_in[19:15]);
  assign w_sh5   = XLEN'(w_in[24:20]);
  assign w_sh6   = XLEN'(w_in[25:20]);

  always_comb begin
    w_imm = '0;
    w_fmt = F_NONE;
    w_ill = 1'b0;
    unique case (w_in[6:0])
      OP_IMM: begin
        w_fmt = F_I;
        // funct3 x01 selects slli/srli/srai
        if (w_f3[1:0] == 2'b01) begin
          w_imm = X64 ? w_sh6 : w_sh5;
          w_ill = !X64 && w_in[25];
        end else begin
          w_imm = w_imm_i;
        end
      end
      OP_IMM32: begin
        if (X64) begin
          w_fmt = F_I;
          w_imm = (w_f3[1:0] == 2'b01) ? w_sh5 : w_imm_i;
        end else begin
          w_ill = 1'b1;
        end
      end
      OP_LOAD, OP_JALR, OP_FENCE: begin
        w_fmt = F_I;
        w_imm = w_imm_i;
      end
      OP_STORE: begin
        w_fmt = F_S;
        w_imm = w_imm_s;
      end
      OP_BR: begin
        w_fmt = F_B;
        w_imm = w_imm_b;
      end
      OP_LUI, OP_AUIPC: begin
        w_fmt = F_U;
        w_imm = w_imm_u;
      end
      OP_JAL: begin
        w_fmt = F_J;
        w_imm = w_imm_j;
      end
      OP_SYS: begin
        if (w_f3[2]) begin
          w_fmt = F_Z;
          w_imm = w_zimm;
        end else begin
          w_fmt = F_I;
          w_imm = w_imm_i;
        end
      end
      OP_REG: w_fmt = F_R;
      OP_REG32: begin
        if (X64) w_fmt = F_R;
        else     w_ill = 1'b1;
      end
      default: w_ill = 1'b1;
    endcase
  end

  assign w_ent = '{imm: w_imm, fmt: w_fmt,
                   ill: w_ill, tag: bus.i_tag};

  ent_t       r_mem [2];
  logic       r_wp;
  logic       r_rp;
  logic [1:0] r_cnt;

  logic w_vld;
  logic w_rdy;
  logic w_push;
  logic w_pop;
  ent_t w_head;

  assign w_vld  = (r_cnt != 2'd0);
  assign w_rdy  = (r_cnt != 2'd2);
  assign w_push = bus.i_valid && w_rdy;
  assign w_pop  = w_vld && bus.i_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wp     <= 1'b0;
      r_rp     <= 1'b0;
      r_cnt    <= 2'd0;
    end else if (i_flush) begin
      r_wp  <= 1'b0;
      r_rp  <= 1'b0;
      r_cnt <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= w_ent;
        r_wp        <= ~r_wp;
      end
      if (w_pop) r_rp <= ~r_rp;
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  // Outputs read zero whenever the buffer is empty.
  assign w_head = w_vld ? r_mem[r_rp] : '0;

  assign bus.o_valid   = w_vld;
  assign bus.o_ready   = w_rdy;
  assign bus.o_imm     = w_head.imm;
  assign bus.o_fmt     = w_head.fmt;
  assign bus.o_illegal = w_head.ill;
  assign bus.o_tag     = w_head.tag;

endmodule
